// File: rtl/proc_mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between the
// instruction-fetch (imem) and data (dmem) ports. An in-order tag FIFO
// remembers which port issued each outstanding request so that every
// memory response is steered back to its originator.
module proc_mem_port_arbiter #(
  parameter int p_req_nbits    = 77,
  parameter int p_resp_nbits   = 47,
  parameter int p_max_inflight = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    imemreq_val,
  output logic                    imemreq_rdy,
  input  logic [p_req_nbits-1:0]  imemreq_msg,
  input  logic                    dmemreq_val,
  output logic                    dmemreq_rdy,
  input  logic [p_req_nbits-1:0]  dmemreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic [p_req_nbits-1:0]  memreq_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,
  input  logic [p_resp_nbits-1:0] memresp_msg,
  output logic                    imemresp_val,
  input  logic                    imemresp_rdy,
  output logic [p_resp_nbits-1:0] imemresp_msg,
  output logic                    dmemresp_val,
  input  logic                    dmemresp_rdy,
  output logic [p_resp_nbits-1:0] dmemresp_msg
);

  localparam int c_cnt_w = $clog2(p_max_inflight + 1);
  localparam int c_ptr_w = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(p_max_inflight);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(p_max_inflight - 1);

  // Tag encoding: which port a request came from.
  localparam logic c_id_imem = 1'b0;
  localparam logic c_id_dmem = 1'b1;

  // Advance a FIFO pointer, wrapping at the FIFO depth (which need not be a power of two).
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
    if (ptr == c_ptr_last) begin
      ptr_inc = {c_ptr_w{1'b0}};
    end else begin
      ptr_inc = ptr + c_ptr_w'(1);
    end
  endfunction

  logic                      prio_q, prio_d;   // 0: dmem wins a contest, 1: imem wins
  logic [p_max_inflight-1:0] tags_q, tags_d;
  logic [c_ptr_w-1:0]        head_q, head_d;
  logic [c_ptr_w-1:0]        tail_q, tail_d;
  logic [c_cnt_w-1:0]        count_q, count_d;

  logic run_s;
  logic full_s;
  logic empty_s;
  logic gnt_val_s;
  logic gnt_id_s;
  logic head_id_s;
  logic push_s;
  logic pop_s;

  // While reset is held low every handshake output is forced inactive.
  assign run_s     = reset;
  assign full_s    = (count_q == c_cnt_max);
  assign empty_s   = (count_q == {c_cnt_w{1'b0}});
  assign head_id_s = tags_q[head_q];

  // Round-robin grant between the two request ports.
  always_comb begin
    gnt_val_s = 1'b0;
    gnt_id_s  = c_id_imem;
    if (imemreq_val && dmemreq_val) begin
      gnt_val_s = 1'b1;
      gnt_id_s  = prio_q ? c_id_imem : c_id_dmem;
    end else if (dmemreq_val) begin
      gnt_val_s = 1'b1;
      gnt_id_s  = c_id_dmem;
    end else if (imemreq_val) begin
      gnt_val_s = 1'b1;
      gnt_id_s  = c_id_imem;
    end else begin
      gnt_val_s = 1'b0;
      gnt_id_s  = c_id_imem;
    end
  end

  // Request path: forward the granted message; back-pressure when the tag FIFO is full.
  always_comb begin
    memreq_val  = run_s & gnt_val_s & ~full_s;
    imemreq_rdy = run_s & gnt_val_s & (gnt_id_s == c_id_imem) & memreq_rdy & ~full_s;
    dmemreq_rdy = run_s & gnt_val_s & (gnt_id_s == c_id_dmem) & memreq_rdy & ~full_s;
    if (run_s && gnt_val_s) begin
      memreq_msg = (gnt_id_s == c_id_dmem) ? dmemreq_msg : imemreq_msg;
    end else begin
      memreq_msg = {p_req_nbits{1'b0}};
    end
  end

  // Response path: the oldest outstanding tag decides which port sees the response.
  always_comb begin
    imemresp_val = run_s & memresp_val & ~empty_s & (head_id_s == c_id_imem);
    dmemresp_val = run_s & memresp_val & ~empty_s & (head_id_s == c_id_dmem);
    memresp_rdy  = run_s & ~empty_s & ((head_id_s == c_id_dmem) ? dmemresp_rdy : imemresp_rdy);
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
  end

  assign push_s = memreq_val & memreq_rdy;
  assign pop_s  = memresp_val & memresp_rdy;

  // Next-state for the priority bit and the tag FIFO.
  always_comb begin
    prio_d  = prio_q;
    tags_d  = tags_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_s) begin
      tags_d[tail_q] = gnt_id_s;
      tail_d         = ptr_inc(tail_q);
      prio_d         = (gnt_id_s == c_id_dmem) ? 1'b1 : 1'b0;
    end else begin
      tail_d = tail_q;
      prio_d = prio_q;
    end
    if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q  <= 1'b0;
      tags_q  <= {p_max_inflight{1'b0}};
      head_q  <= {c_ptr_w{1'b0}};
      tail_q  <= {c_ptr_w{1'b0}};
      count_q <= {c_cnt_w{1'b0}};
    end else begin
      prio_q  <= prio_d;
      tags_q  <= tags_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Self-checking bench for proc_mem_port_arbiter: a directed vector table,
// hand-written multi-cycle sequences, and a randomized phase compared
// against a queue-based reference model.
module tb_proc_mem_port_arbiter;

  localparam int REQ  = 77;
  localparam int RESP = 47;
  localparam int MAXI = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            imemreq_val, imemreq_rdy;
  logic [REQ-1:0]  imemreq_msg;
  logic            dmemreq_val, dmemreq_rdy;
  logic [REQ-1:0]  dmemreq_msg;
  logic            memreq_val, memreq_rdy;
  logic [REQ-1:0]  memreq_msg;
  logic            memresp_val, memresp_rdy;
  logic [RESP-1:0] memresp_msg;
  logic            imemresp_val, imemresp_rdy;
  logic [RESP-1:0] imemresp_msg;
  logic            dmemresp_val, dmemresp_rdy;
  logic [RESP-1:0] dmemresp_msg;

  always #5 clk = ~clk;

  proc_mem_port_arbiter #(.p_req_nbits(REQ), .p_resp_nbits(RESP), .p_max_inflight(MAXI)) dut (
    .clk(clk), .reset(reset),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_msg(imemreq_msg),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_msg(dmemreq_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_msg(imemresp_msg),
    .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_msg(dmemresp_msg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request: type/opaque/addr/len/data ; response: type/opaque/test/len/data
  function automatic logic [REQ-1:0] mk_req(input logic [31:0] addr);
    mk_req = {3'd0, 8'h00, addr, 2'd0, addr ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [RESP-1:0] mk_resp(input logic [31:0] data);
    mk_resp = {3'd0, 8'h00, 2'd0, 2'd0, data};
  endfunction

  task automatic set_in(input logic iv, input logic dv, input logic [31:0] ia, input logic [31:0] da,
                        input logic mr, input logic rv, input logic [31:0] rdata,
                        input logic irr, input logic drr);
    imemreq_val  = iv;  imemreq_msg = mk_req(ia);
    dmemreq_val  = dv;  dmemreq_msg = mk_req(da);
    memreq_rdy   = mr;
    memresp_val  = rv;  memresp_msg = mk_resp(rdata);
    imemresp_rdy = irr; dmemresp_rdy = drr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  bit              mq[$];        // outstanding requester IDs, oldest first (0 imem, 1 dmem)
  bit              m_fav_imem;   // imem wins the next contest
  bit              e_gval, e_gid, e_mval, e_irdy, e_drdy, e_mrdy, e_iv, e_dv;
  logic [REQ-1:0]  e_msg;

  task automatic model_eval();
    bit full, empty, head;
    e_gval = imemreq_val | dmemreq_val;
    if (imemreq_val && dmemreq_val) e_gid = m_fav_imem ? 1'b0 : 1'b1;
    else                            e_gid = dmemreq_val;
    full   = (mq.size() == MAXI);
    empty  = (mq.size() == 0);
    head   = empty ? 1'b0 : mq[0];
    e_mval = e_gval && !full;
    e_irdy = e_mval && !e_gid && memreq_rdy;
    e_drdy = e_mval &&  e_gid && memreq_rdy;
    e_msg  = !e_gval ? '0 : (e_gid ? dmemreq_msg : imemreq_msg);
    e_iv   = memresp_val && !empty && !head;
    e_dv   = memresp_val && !empty &&  head;
    e_mrdy = !empty && (head ? dmemresp_rdy : imemresp_rdy);
  endtask

  task automatic model_compare();
    chk1("rnd_memreq_val", memreq_val, e_mval);
    chk1("rnd_imemreq_rdy", imemreq_rdy, e_irdy);
    chk1("rnd_dmemreq_rdy", dmemreq_rdy, e_drdy);
    chkw("rnd_memreq_msg", 128'(memreq_msg), 128'(e_msg));
    chk1("rnd_memresp_rdy", memresp_rdy, e_mrdy);
    chk1("rnd_imemresp_val", imemresp_val, e_iv);
    chk1("rnd_dmemresp_val", dmemresp_val, e_dv);
    chkw("rnd_imemresp_msg", 128'(imemresp_msg), 128'(memresp_msg));
    chkw("rnd_dmemresp_msg", 128'(dmemresp_msg), 128'(memresp_msg));
  endtask

  task automatic model_update();
    bit do_push, do_pop;
    do_push = e_mval && memreq_rdy;
    do_pop  = memresp_val && e_mrdy;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(e_gid);
      m_fav_imem = e_gid;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv, dv;
    logic [31:0] ia, da;
    logic        mr, rv, irr, drr;
    logic        x_mval, x_irdy, x_drdy;
    logic [1:0]  x_sel;    // 0 none, 1 imem msg, 2 dmem msg, 3 not compared (full)
    logic        x_mrdy, x_iv, x_dv;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // fairness from reset with a response each cycle
    vecs[0]  = '{1'b1,1'b1,32'h100,32'h300,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,32'h104,32'h304,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b1,32'h108,32'h308,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,2'd2,1'b1,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b1,32'h10c,32'h30c,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b0,32'h0,  32'h0,  1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0};
    // orphan response on an empty FIFO
    vecs[5]  = '{1'b0,1'b0,32'h0,  32'h0,  1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
    // single requester back-to-back
    vecs[6]  = '{1'b1,1'b0,32'h200,32'h0,  1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b0,32'h204,32'h0,  1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,32'h208,32'h0,  1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
    // memreq_val independent of memreq_rdy, then the 4th fire fills the FIFO
    vecs[9]  = '{1'b0,1'b1,32'h0,  32'h310,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,2'd2,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,32'h0,  32'h314,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,2'd2,1'b1,1'b0,1'b0};
    // full: blocked; pop frees a slot; next cycle refills
    vecs[11] = '{1'b1,1'b1,32'h210,32'h318,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd3,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,32'h210,32'h318,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd3,1'b1,1'b1,1'b0};
    vecs[13] = '{1'b1,1'b1,32'h210,32'h318,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,2'd1,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b1,32'h214,32'h31c,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,2'd3,1'b0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b0,32'h0,  32'h0,  1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd0,1'b1,1'b1,1'b0};

    // -------- reset state: everything inactive while reset is low --------
    reset = 1'b0;
    set_in(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    #3;
    chk1("rst_memreq_val", memreq_val, 1'b0);
    chk1("rst_imemreq_rdy", imemreq_rdy, 1'b0);
    chk1("rst_dmemreq_rdy", dmemreq_rdy, 1'b0);
    chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
    chk1("rst_imemresp_val", imemresp_val, 1'b0);
    chk1("rst_dmemresp_val", dmemresp_val, 1'b0);
    chkw("rst_memreq_msg", 128'(memreq_msg), 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // -------- table --------
    for (int i = 0; i < 16; i++) begin
      logic [REQ-1:0] xm;
      set_in(vecs[i].iv, vecs[i].dv, vecs[i].ia, vecs[i].da, vecs[i].mr, vecs[i].rv,
             32'h1000 + 32'(i), vecs[i].irr, vecs[i].drr);
      #1;
      case (vecs[i].x_sel)
        2'd1:    xm = mk_req(vecs[i].ia);
        2'd2:    xm = mk_req(vecs[i].da);
        default: xm = '0;
      endcase
      chk1($sformatf("vec%0d_memreq_val", i), memreq_val, vecs[i].x_mval);
      chk1($sformatf("vec%0d_imemreq_rdy", i), imemreq_rdy, vecs[i].x_irdy);
      chk1($sformatf("vec%0d_dmemreq_rdy", i), dmemreq_rdy, vecs[i].x_drdy);
      if (vecs[i].x_sel != 2'd3)
        chkw($sformatf("vec%0d_memreq_msg", i), 128'(memreq_msg), 128'(xm));
      chk1($sformatf("vec%0d_memresp_rdy", i), memresp_rdy, vecs[i].x_mrdy);
      chk1($sformatf("vec%0d_imemresp_val", i), imemresp_val, vecs[i].x_iv);
      chk1($sformatf("vec%0d_dmemresp_val", i), dmemresp_val, vecs[i].x_dv);
      tick();
    end

    // -------- ordering and stall: fire I, D, I then return A, B, C --------
    do_reset();
    set_in(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); #1;
    chk1("ord_fire_i0", imemreq_rdy, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'h0, 32'h500, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); #1;
    chk1("ord_fire_d", dmemreq_rdy, 1'b1); tick();
    set_in(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); #1;
    chk1("ord_fire_i1", imemreq_rdy, 1'b1); tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hA, 1'b1, 1'b1); #1;
    chk1("ord_a_ival", imemresp_val, 1'b1);
    chk1("ord_a_dval", dmemresp_val, 1'b0);
    chk1("ord_a_rdy", memresp_rdy, 1'b1);
    chkw("ord_a_msg", 128'(imemresp_msg), 128'(mk_resp(32'hA)));
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hB, 1'b1, 1'b0); #1;
    chk1("ord_b_stall_dval", dmemresp_val, 1'b1);
    chk1("ord_b_stall_ival", imemresp_val, 1'b0);
    chk1("ord_b_stall_rdy", memresp_rdy, 1'b0);
    chkw("ord_b_msg", 128'(dmemresp_msg), 128'(mk_resp(32'hB)));
    tick(); #1;
    chk1("ord_b_held_dval", dmemresp_val, 1'b1);
    chk1("ord_b_held_rdy", memresp_rdy, 1'b0);
    @(negedge clk);
    dmemresp_rdy = 1'b1; #1;
    chk1("ord_b_release_rdy", memresp_rdy, 1'b1);
    chk1("ord_b_release_dval", dmemresp_val, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1); #1;
    chk1("ord_c_ival", imemresp_val, 1'b1);
    chk1("ord_c_dval", dmemresp_val, 1'b0);
    chk1("ord_c_rdy", memresp_rdy, 1'b1);
    chkw("ord_c_msg", 128'(imemresp_msg), 128'(mk_resp(32'hC)));
    tick(); #1;
    chk1("ord_empty_rdy", memresp_rdy, 1'b0);
    chk1("ord_empty_ival", imemresp_val, 1'b0);
    @(negedge clk);

    // -------- asynchronous reset with two in flight --------
    do_reset();
    set_in(1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'h0, 32'h700, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    set_in(1'b1, 1'b1, 32'h604, 32'h704, 1'b1, 1'b1, 32'h77, 1'b1, 1'b1); #1;
    chk1("arst_pre_ival", imemresp_val, 1'b1);
    chk1("arst_pre_mval", memreq_val, 1'b1);
    #1 reset = 1'b0; #1;
    chk1("arst_memreq_val", memreq_val, 1'b0);
    chk1("arst_imemreq_rdy", imemreq_rdy, 1'b0);
    chk1("arst_dmemreq_rdy", dmemreq_rdy, 1'b0);
    chk1("arst_memresp_rdy", memresp_rdy, 1'b0);
    chk1("arst_imemresp_val", imemresp_val, 1'b0);
    chk1("arst_dmemresp_val", dmemresp_val, 1'b0);
    chkw("arst_memreq_msg", 128'(memreq_msg), 128'd0);
    @(negedge clk);
    reset = 1'b1; #1;
    chk1("arst_post_dgrant", dmemreq_rdy, 1'b1);
    chk1("arst_post_igrant", imemreq_rdy, 1'b0);
    chkw("arst_post_msg", 128'(memreq_msg), 128'(mk_req(32'h704)));
    chk1("arst_post_empty_rdy", memresp_rdy, 1'b0);
    chk1("arst_post_empty_ival", imemresp_val, 1'b0);
    @(negedge clk);

    // -------- randomized phase against the reference model --------
    do_reset();
    mq.delete();
    m_fav_imem = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      imemreq_val  = ($urandom_range(0, 2) != 0);
      dmemreq_val  = ($urandom_range(0, 2) != 0);
      imemreq_msg  = REQ'({$urandom(), $urandom(), $urandom()});
      dmemreq_msg  = REQ'({$urandom(), $urandom(), $urandom()});
      memreq_rdy   = ($urandom_range(0, 3) != 0);
      memresp_val  = ($urandom_range(0, 2) != 0);
      memresp_msg  = RESP'({$urandom(), $urandom()});
      imemresp_rdy = ($urandom_range(0, 3) != 0);
      dmemresp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      model_compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_mem_port_arbiter.md
Name: proc_mem_port_arbiter

Overview:
Shares one single-ported test memory between the processor's instruction-fetch port (imem) and data port (dmem). Requests are arbitrated round-robin onto one memreq port. The requester ID is recorded in an in-order tag FIFO so that each memresp is steered back to its originator. The block sits between the 5-stage pipelined processor and the memory, so single-port memory configurations run unmodified processor code.

Parameters:
p_req_nbits, 77, width of a flattened 4B memory request message (type/opaque/addr/len/data)
p_resp_nbits, 47, width of a flattened 4B memory response message (type/opaque/test/len/data)
p_max_inflight, 4, maximum outstanding requests (tag FIFO depth, >=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imemreq_val  input  1  fetch request valid
imemreq_rdy  output  1  fetch request accepted
imemreq_msg  input  p_req_nbits  fetch request message
dmemreq_val  input  1  data request valid
dmemreq_rdy  output  1  data request accepted
dmemreq_msg  input  p_req_nbits  data request message
memreq_val  output  1  shared request valid
memreq_rdy  input  1  memory accepts request
memreq_msg  output  p_req_nbits  granted request message
memresp_val  input  1  memory response valid
memresp_rdy  output  1  response consumed
memresp_msg  input  p_resp_nbits  memory response message
imemresp_val  output  1  response to fetch port
imemresp_rdy  input  1  fetch port ready
imemresp_msg  output  p_resp_nbits  copy of memresp_msg
dmemresp_val  output  1  response to data port
dmemresp_rdy  input  1  data port ready
dmemresp_msg  output  p_resp_nbits  copy of memresp_msg

Behaviour:
- State: priority bit prio (0 = dmem favoured), tag FIFO of p_max_inflight 1-bit IDs (0 = imem, 1 = dmem), head/tail pointers, and count of width $clog2(p_max_inflight+1).
- full = (count == p_max_inflight). empty = (count == 0).
- Grant is combinational.
  - If only one requester is valid, it gets the grant.
  - If both are valid, dmem is granted when prio = 0, imem when prio = 1.
- memreq_val = (imemreq_val | dmemreq_val) & ~full. memreq_val never depends on memreq_rdy.
- memreq_msg = message of the granted requester; all-zero when there is no grant.
- Request ready signals: granted requester rdy = memreq_rdy & ~full; the other rdy = 0.
- Request fire (memreq_val & memreq_rdy):
  - push the granted ID at the tail; tail wraps modulo p_max_inflight.
  - prio <= (granted == dmem) ? 1 : 0, i.e. priority goes to the other requester.
  - With no fire, prio holds.
- Push is blocked when full, even if a pop occurs in the same cycle. There is no rdy-to-rdy combinational path.
- Response steering:
  - head = ID at FIFO head.
  - imemresp_val = memresp_val & ~empty & (head == 0).
  - dmemresp_val = memresp_val & ~empty & (head == 1).
  - memresp_rdy = ~empty & (head ? dmemresp_rdy : imemresp_rdy).
  - Both resp_msg outputs equal memresp_msg unconditionally.
- Response fire pops the head; head wraps modulo p_max_inflight.
- Latency: zero added cycles on both paths. A response may fire the cycle after its request. There is no same-cycle request-to-response bypass: a response with an empty FIFO is not accepted.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- memresp_val while empty is a protocol violation. memresp_rdy = 0 and the response is stalled, not dropped.
- Reset (reset == 0, asynchronous):
  - count, head, tail and prio clear to 0 immediately.
  - while reset is low, all val and rdy outputs are 0 and memreq_msg is all-zero.
  - reset mid-operation discards all in-flight tags. Memory must be reset in the same window.
- No state change occurs on any cycle without a fire.

Test Plan:
1. Fairness after reset: imem and dmem both valid continuously, memreq_rdy = 1, responses returned each cycle -> grants dmem, imem, dmem, imem on consecutive cycles.
2. Single requester: only imemreq_val high for 3 cycles with messages addr 0x200, 0x204, 0x208 -> three back-to-back memreq fires with those addresses; dmemreq_rdy = 0 throughout.
3. Full back-pressure (p_max_inflight = 4): 4 request fires with memresp_val = 0.
   - Cycle 5 -> memreq_val = 0 and both req rdy = 0.
   - One response pops -> a request fires the next cycle, count returns to 4.
4. Ordering and stall: fire I, D, I; return 3 responses with data 0xA, 0xB, 0xC -> 0xA to imem, 0xB to dmem, 0xC to imem.
   - With dmemresp_rdy = 0 during the second response -> memresp_rdy = 0 and 0xB is held until dmemresp_rdy = 1.
5. Orphan response: memresp_val = 1 with empty FIFO -> memresp_rdy = 0, imemresp_val = dmemresp_val = 0, state unchanged.
6. Asynchronous reset with 2 in flight, asserted mid-cycle -> all val/rdy outputs drop before the next edge. After release, count = 0 and the first contested grant goes to dmem.
